fft_iter_ctrl: RTL and testbench

FFT_ITER_CTRL -- requirements
Module: fft_iter_ctrl

---
 rtl/fft_iter_pkg.sv | 17 +
 rtl/fft_addr_delay.sv | 38 +++
 rtl/fft_iter_ctrl.sv | 140 ++++++++++++++
 tb/tb_fft_iter_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fft_iter_pkg.sv
// Shared types and constants for the iterative FFT address/strobe controller.
package fft_iter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Cycles from an operand read strobe to the matching write-back strobe.
    function automatic int unsigned drain_len(input int unsigned rd_lat,
                                              input int unsigned but_lat);
        return rd_lat + but_lat;
    endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register for strobes and addresses; cleared on reset.
module fft_addr_delay
    import fft_iter_pkg::*;
#(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe_q [DEPTH];
    logic [W-1:0] pipe_d [DEPTH];

    // Next value of each tap: input feeds tap 0, every other tap takes its predecessor.
    always_comb begin
        pipe_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Tap registers; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rst) begin
                pipe_q[i] <= '0;
            end else begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_iter_ctrl.sv
// Iterative radix-2 DIT FFT controller: issues one butterfly per cycle per stage,
// drains the read/butterfly pipeline between stages, and schedules in-place write-back.
module fft_iter_ctrl
    import fft_iter_pkg::*;
#(
    parameter int unsigned N_LOG2  = 3,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned BUT_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_LOG2-1:0] stage,
    output logic              rd_en,
    output logic [N_LOG2-1:0] rd_addr_a,
    output logic [N_LOG2-1:0] rd_addr_b,
    output logic [N_LOG2-2:0] tw_addr,
    output logic              but_strb,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_addr_a,
    output logic [N_LOG2-1:0] wr_addr_b
);

    localparam int unsigned D  = drain_len(RD_LAT, BUT_LAT);
    localparam int unsigned KW = N_LOG2 - 1;
    localparam int unsigned CW = 4;
    localparam int unsigned DW = 2 * N_LOG2 + 1;

    state_e            state_q, state_d;
    logic [N_LOG2-1:0] stage_q, stage_d;
    logic [KW-1:0]     k_q, k_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [N_LOG2-1:0] kx, span, mask, pos, addr_a, addr_b, shamt, tw_full;
    logic [DW-1:0]     wr_pipe;

    // Next-state logic: issue loop, fixed-length drain, stage advance, done pulse.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    stage_d = '0;
                    k_d     = '0;
                end
            end
            RUN: begin
                k_d = k_q + KW'(1);
                if (k_q == '1) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(D - 1)) begin
                    if (stage_q == N_LOG2'(N_LOG2 - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        stage_d = stage_q + N_LOG2'(1);
                        k_d     = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operand/twiddle addresses: A inserts a 0 bit at position 'stage' into k,
    // B is A with that bit set; twiddle index is pos scaled to the full ROM range.
    always_comb begin
        kx      = {1'b0, k_q};
        span    = N_LOG2'(1) << stage_q;
        mask    = span - N_LOG2'(1);
        pos     = kx & mask;
        addr_a  = ((kx & ~mask) << 1) | pos;
        addr_b  = addr_a | span;
        shamt   = N_LOG2'(N_LOG2 - 1) - stage_q;
        tw_full = pos << shamt;
    end

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign stage     = stage_q;
    assign rd_en     = (state_q == RUN);
    assign rd_addr_a = rd_en ? addr_a : '0;
    assign rd_addr_b = rd_en ? addr_b : '0;
    assign tw_addr   = rd_en ? tw_full[N_LOG2-2:0] : '0;

    fft_addr_delay #(
        .W     (1),
        .DEPTH (RD_LAT)
    ) u_strb_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_en),
        .dout (but_strb)
    );

    fft_addr_delay #(
        .W     (DW),
        .DEPTH (D)
    ) u_wr_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en, rd_addr_a, rd_addr_b}),
        .dout (wr_pipe)
    );

    assign wr_en     = wr_pipe[DW-1];
    assign wr_addr_a = wr_en ? wr_pipe[2*N_LOG2-1:N_LOG2] : '0;
    assign wr_addr_b = wr_en ? wr_pipe[N_LOG2-1:0] : '0;

endmodule

// File: tb/tb_fft_iter_ctrl.sv
// Directed bench for fft_iter_ctrl with N_LOG2=3, RD_LAT=1, BUT_LAT=3.
module tb_fft_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, rd_en, but_strb, wr_en;
    logic [2:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [1:0] tw_addr;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-derived issue tables for the three stages, in issue order.
    logic [2:0] ea  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] eb  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [1:0] etw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    fft_iter_ctrl #(
        .N_LOG2  (3),
        .RD_LAT  (1),
        .BUT_LAT (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .but_strb  (but_strb),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        step();
        step();
        n_cmp++;
        if ({busy, done, rd_en, but_strb, wr_en} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl got=%b exp=00000", {busy, done, rd_en, but_strb, wr_en});
        end
        n_cmp++;
        if ({stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b} !== 17'b0) begin
            n_err++;
            $display("FAIL reset_addr got=%h exp=0",
                     {stage, rd_addr_a, rd_addr_b, tw_addr, wr_addr_a, wr_addr_b});
        end
        rst = 1'b0;
    endtask

    // Full transform from cycle 0, with ignored starts at 3 and 25 and a restart at 26.
    task automatic test_full_run();
        int ri = 0;
        int wi = 0;
        logic ex_rd, ex_wr, ex_bs, ex_busy, ex_done;
        start = 1'b1;
        for (int cyc = 1; cyc <= 27; cyc++) begin
            step();
            start = (cyc == 3) || (cyc == 25) || (cyc == 26);
            ex_rd   = (cyc >= 1 && cyc <= 4) || (cyc >= 9 && cyc <= 12) ||
                      (cyc >= 17 && cyc <= 20) || (cyc == 27);
            ex_bs   = (cyc >= 2 && cyc <= 5) || (cyc >= 10 && cyc <= 13) ||
                      (cyc >= 18 && cyc <= 21);
            ex_wr   = (cyc >= 5 && cyc <= 8) || (cyc >= 13 && cyc <= 16) ||
                      (cyc >= 21 && cyc <= 24);
            ex_busy = (cyc >= 1 && cyc <= 24) || (cyc == 27);
            ex_done = (cyc == 25);
            if (cyc == 27) ri = 0;
            n_cmp++;
            if ({busy, done, rd_en, but_strb, wr_en} !== {ex_busy, ex_done, ex_rd, ex_bs, ex_wr}) begin
                n_err++;
                $display("FAIL run_ctl cyc=%0d got(busy,done,rd,bs,wr)=%b exp=%b", cyc,
                         {busy, done, rd_en, but_strb, wr_en}, {ex_busy, ex_done, ex_rd, ex_bs, ex_wr});
            end
            if (ex_rd) begin
                n_cmp++;
                if ({stage, rd_addr_a, rd_addr_b, tw_addr} !== {3'(ri / 4), ea[ri], eb[ri], etw[ri]}) begin
                    n_err++;
                    $display("FAIL run_rd cyc=%0d got stg=%0d a=%0d b=%0d tw=%0d exp stg=%0d a=%0d b=%0d tw=%0d",
                             cyc, stage, rd_addr_a, rd_addr_b, tw_addr, ri / 4, ea[ri], eb[ri], etw[ri]);
                end
                ri++;
            end else begin
                n_cmp++;
                if ({rd_addr_a, rd_addr_b, tw_addr} !== 8'b0) begin
                    n_err++;
                    $display("FAIL run_rd_idle cyc=%0d got a=%0d b=%0d tw=%0d exp 0", cyc,
                             rd_addr_a, rd_addr_b, tw_addr);
                end
            end
            if (ex_wr) begin
                n_cmp++;
                if ({wr_addr_a, wr_addr_b} !== {ea[wi], eb[wi]}) begin
                    n_err++;
                    $display("FAIL run_wr cyc=%0d got a=%0d b=%0d exp a=%0d b=%0d", cyc,
                             wr_addr_a, wr_addr_b, ea[wi], eb[wi]);
                end
                wi++;
            end else begin
                n_cmp++;
                if ({wr_addr_a, wr_addr_b} !== 6'b0) begin
                    n_err++;
                    $display("FAIL run_wr_idle cyc=%0d got a=%0d b=%0d exp 0", cyc, wr_addr_a, wr_addr_b);
                end
            end
        end
        start = 1'b0;
    endtask

    // Reset asserted during cycle 10 of a run flushes everything from cycle 11 on.
    task automatic test_reset_mid();
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b1;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            step();
            start = 1'b0;
            rst = (cyc == 10);
            if (cyc == 6) begin
                n_cmp++;
                if ({wr_en, wr_addr_a, wr_addr_b} !== {1'b1, 3'd2, 3'd3}) begin
                    n_err++;
                    $display("FAIL mid_prewr got=%b exp=1010011", {wr_en, wr_addr_a, wr_addr_b});
                end
            end
            if (cyc == 10) begin
                n_cmp++;
                if ({rd_en, stage, rd_addr_a, rd_addr_b} !== {1'b1, 3'd1, 3'd1, 3'd3}) begin
                    n_err++;
                    $display("FAIL mid_prerd got=%b exp=1001001011", {rd_en, stage, rd_addr_a, rd_addr_b});
                end
            end
            if (cyc >= 11) begin
                n_cmp++;
                if ({busy, done, rd_en, but_strb, wr_en, stage, rd_addr_a, rd_addr_b, tw_addr,
                     wr_addr_a, wr_addr_b} !== 22'b0) begin
                    n_err++;
                    $display("FAIL mid_flush cyc=%0d got=%b exp=0", cyc,
                             {busy, done, rd_en, but_strb, wr_en, stage, rd_addr_a, rd_addr_b,
                              tw_addr, wr_addr_a, wr_addr_b});
                end
            end
        end
    endtask

    // Reset wins over a coincident start.
    task automatic test_rst_start();
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            n_cmp++;
            if ({busy, rd_en, wr_en} !== 3'b0) begin
                n_err++;
                $display("FAIL rst_start cyc=%0d got(busy,rd,wr)=%b exp=000", cyc, {busy, rd_en, wr_en});
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_reset_mid();
        test_rst_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
